morse_rx_decoder: RTL and testbench

Receive-side companion to the Morse/SOS beacon generator. It samples a hand key or opto input, times marks and spaces in Morse units, assembles dot/dash elements into symbols and reports each completed symbol. It also flags SOS, either as the 9-element prosign or as the letters S, O, S, and drives a sidetone output while the key is down. It sits between the board key input and the LED/UART display logic.

---
 rtl/morse_rx_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_morse_rx_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_rx_decoder.sv
// Morse receiver: times key marks/spaces in units, assembles dot/dash symbols, flags SOS.
// Define MORSE_ASCII_EN to build the A-Z/0-9 lookup that drives oASCII.

module morse_rx_decoder #(
    parameter int UNIT_CYCLES = 6250000,
    parameter int DASH_MIN    = 2,
    parameter int LETTER_GAP  = 2,
    parameter int WORD_GAP    = 5,
    parameter int MARK_MAX    = 15,
    parameter int TONE_BIT    = 17
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iKEY,
    output logic       oCHAR_VALID,
    output logic [8:0] oSYM_BITS,
    output logic [3:0] oSYM_LEN,
    output logic       oWORD,
    output logic       oSOS,
    output logic       oERR,
    output logic [7:0] oASCII,
    output logic       oSOUND
);
    localparam int PW = $clog2(UNIT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_MARK, S_STUCK, S_SPACE, S_GAP} state_t;
    typedef enum logic [1:0] {K_OTHER, K_S, K_O} kind_t;

    logic          key_meta_q, key_q, key_prev_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    dur_q, dur_d, dur_inc, dur_eff;
    logic [17:0]   tone_q;

    state_t        state_q;
    logic [8:0]    buf_q;
    logic [3:0]    cnt_q;
    logic          ovf_q;
    kind_t         hist_old_q, hist_new_q, kind_d;

    logic key_edge, rise, fall, tick;
    logic stuck_hit, letter_hit, word_hit;
    logic elem_d, sos_d;

    assign key_edge = key_q ^ key_prev_q;
    assign rise     = key_q & ~key_prev_q;
    assign fall     = ~key_q & key_prev_q;
    assign tick     = (pre_q == PW'(UNIT_CYCLES - 1));

    assign pre_d   = (key_edge || tick) ? '0 : pre_q + 1'b1;
    assign dur_inc = (dur_q == 4'd15) ? 4'd15 : dur_q + 4'd1;
    assign dur_eff = tick ? dur_inc : dur_q;
    assign dur_d   = key_edge ? 4'd0 : dur_eff;

    // Threshold events fire on the crossing tick only; a coincident edge suppresses them.
    assign stuck_hit  = tick && !key_edge && (dur_q == 4'(MARK_MAX - 1));
    assign letter_hit = tick && !key_edge && (dur_q == 4'(LETTER_GAP - 1));
    assign word_hit   = tick && !key_edge && (dur_q == 4'(WORD_GAP - 1));

    // A mark ending exactly on a unit boundary counts that final unit.
    assign elem_d = (dur_eff >= 4'(DASH_MIN));

    always_comb begin
        kind_d = K_OTHER;
        if (cnt_q == 4'd3 && buf_q == 9'b000000000) kind_d = K_S;
        if (cnt_q == 4'd3 && buf_q == 9'b000000111) kind_d = K_O;
    end

    assign sos_d = (cnt_q == 4'd9 && buf_q == 9'b000111000) ||
                   (hist_old_q == K_S && hist_new_q == K_O && kind_d == K_S);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            key_meta_q <= 1'b0;
            key_q      <= 1'b0;
            key_prev_q <= 1'b0;
            pre_q      <= '0;
            dur_q      <= 4'd0;
            tone_q     <= 18'd0;
        end else begin
            key_meta_q <= iKEY;
            key_q      <= key_meta_q;
            key_prev_q <= key_q;
            pre_q      <= pre_d;
            dur_q      <= dur_d;
            tone_q     <= tone_q + 18'd1;
        end
    end

    assign oSOUND = key_q & tone_q[TONE_BIT];

`ifdef MORSE_ASCII_EN
    logic [7:0] ascii_d;

    function automatic logic [7:0] morse_lookup(input logic [3:0] len, input logic [8:0] bits);
        logic [7:0] c;
        case ({len, bits})
            {4'd2, 9'd1}:  c = 8'h41;  // A .-
            {4'd4, 9'd8}:  c = 8'h42;  // B -...
            {4'd4, 9'd10}: c = 8'h43;
            {4'd3, 9'd4}:  c = 8'h44;
            {4'd1, 9'd0}:  c = 8'h45;
            {4'd4, 9'd2}:  c = 8'h46;
            {4'd3, 9'd6}:  c = 8'h47;
            {4'd4, 9'd0}:  c = 8'h48;
            {4'd2, 9'd0}:  c = 8'h49;
            {4'd4, 9'd7}:  c = 8'h4A;
            {4'd3, 9'd5}:  c = 8'h4B;
            {4'd4, 9'd4}:  c = 8'h4C;
            {4'd2, 9'd3}:  c = 8'h4D;
            {4'd2, 9'd2}:  c = 8'h4E;
            {4'd3, 9'd7}:  c = 8'h4F;
            {4'd4, 9'd6}:  c = 8'h50;
            {4'd4, 9'd13}: c = 8'h51;
            {4'd3, 9'd2}:  c = 8'h52;
            {4'd3, 9'd0}:  c = 8'h53;
            {4'd1, 9'd1}:  c = 8'h54;
            {4'd3, 9'd1}:  c = 8'h55;
            {4'd4, 9'd1}:  c = 8'h56;
            {4'd3, 9'd3}:  c = 8'h57;
            {4'd4, 9'd9}:  c = 8'h58;
            {4'd4, 9'd11}: c = 8'h59;
            {4'd4, 9'd12}: c = 8'h5A;
            {4'd5, 9'd31}: c = 8'h30;
            {4'd5, 9'd15}: c = 8'h31;
            {4'd5, 9'd7}:  c = 8'h32;
            {4'd5, 9'd3}:  c = 8'h33;
            {4'd5, 9'd1}:  c = 8'h34;
            {4'd5, 9'd0}:  c = 8'h35;
            {4'd5, 9'd16}: c = 8'h36;
            {4'd5, 9'd24}: c = 8'h37;
            {4'd5, 9'd28}: c = 8'h38;
            {4'd5, 9'd30}: c = 8'h39;
            default:       c = 8'h3F;
        endcase
        return c;
    endfunction

    assign ascii_d = morse_lookup(cnt_q, buf_q);
`else
    assign oASCII = 8'h00;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            buf_q       <= 9'd0;
            cnt_q       <= 4'd0;
            ovf_q       <= 1'b0;
            hist_old_q  <= K_OTHER;
            hist_new_q  <= K_OTHER;
            oCHAR_VALID <= 1'b0;
            oSYM_BITS   <= 9'd0;
            oSYM_LEN    <= 4'd0;
            oWORD       <= 1'b0;
            oSOS        <= 1'b0;
            oERR        <= 1'b0;
`ifdef MORSE_ASCII_EN
            oASCII      <= 8'h00;
`endif
        end else begin
            oCHAR_VALID <= 1'b0;
            oWORD       <= 1'b0;
            oSOS        <= 1'b0;
            oERR        <= 1'b0;
            case (state_q)
                S_IDLE: if (rise) state_q <= S_MARK;
                S_MARK: begin
                    if (fall) begin
                        if (cnt_q == 4'd9) begin
                            ovf_q <= 1'b1;
                        end else begin
                            buf_q <= {buf_q[7:0], elem_d};
                            cnt_q <= cnt_q + 4'd1;
                        end
                        state_q <= S_SPACE;
                    end else if (stuck_hit) begin
                        oERR       <= 1'b1;
                        buf_q      <= 9'd0;
                        cnt_q      <= 4'd0;
                        ovf_q      <= 1'b0;
                        hist_old_q <= K_OTHER;
                        hist_new_q <= K_OTHER;
                        state_q    <= S_STUCK;
                    end
                end
                S_STUCK: if (fall) state_q <= S_IDLE;
                S_SPACE: begin
                    if (rise) begin
                        state_q <= S_MARK;
                    end else if (letter_hit) begin
                        if (ovf_q) begin
                            oERR       <= 1'b1;
                            hist_old_q <= K_OTHER;
                            hist_new_q <= K_OTHER;
                        end else begin
                            oCHAR_VALID <= 1'b1;
                            oSYM_BITS   <= buf_q;
                            oSYM_LEN    <= cnt_q;
                            oSOS        <= sos_d;
`ifdef MORSE_ASCII_EN
                            oASCII      <= ascii_d;
`endif
                            hist_old_q  <= hist_new_q;
                            hist_new_q  <= kind_d;
                        end
                        buf_q   <= 9'd0;
                        cnt_q   <= 4'd0;
                        ovf_q   <= 1'b0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (rise) begin
                        state_q <= S_MARK;
                    end else if (word_hit) begin
                        oWORD      <= 1'b1;
                        hist_old_q <= K_OTHER;
                        hist_new_q <= K_OTHER;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Randomised + directed bench for morse_rx_decoder; a segment-level model predicts each pulse and its cycle.
module tb_morse_rx_decoder;
    localparam int UC = 4;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iKEY = 1'b0;
    logic       oCHAR_VALID, oWORD, oSOS, oERR, oSOUND;
    logic [8:0] oSYM_BITS;
    logic [3:0] oSYM_LEN;
    logic [7:0] oASCII;

    morse_rx_decoder #(.UNIT_CYCLES(UC), .DASH_MIN(2), .LETTER_GAP(2), .WORD_GAP(5),
                       .MARK_MAX(15), .TONE_BIT(2)) dut (
        .iCLK(iCLK), .iRST(iRST), .iKEY(iKEY),
        .oCHAR_VALID(oCHAR_VALID), .oSYM_BITS(oSYM_BITS), .oSYM_LEN(oSYM_LEN),
        .oWORD(oWORD), .oSOS(oSOS), .oERR(oERR), .oASCII(oASCII), .oSOUND(oSOUND));

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int         cyc;
        bit         chv, word, err, sos;
        logic [3:0] len;
        logic [8:0] bits;
        logic [7:0] asc;
    } ev_t;

    ev_t   exp_q[$];
    ev_t   last_chr;
    ev_t   mon_e;

    string mtab [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                         "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                         "..-", "...-", ".--", "-..-", "-.--", "--..",
                         "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                         "---..", "----."};
    string alph = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    string cur_sym = "";
    bit    m_ovf = 1'b0;
    string hist[$];

    function automatic logic [7:0] m_ascii(input string s);
        for (int i = 0; i < 36; i++) if (mtab[i] == s) return alph[i];
        return 8'h3F;
    endfunction

    function automatic ev_t mk_ev(input int t, input bit chv, input bit w, input bit er,
                                  input bit sos, input string s);
        ev_t e;
        e.cyc = t; e.chv = chv; e.word = w; e.err = er; e.sos = sos;
        e.len = 4'(s.len());
        e.bits = 9'd0;
        for (int i = 0; i < s.len(); i++) if (s[i] == "-") e.bits[s.len() - 1 - i] = 1'b1;
`ifdef MORSE_ASCII_EN
        e.asc = m_ascii(s);
`else
        e.asc = 8'h00;
`endif
        return e;
    endfunction

    // Key change made at cycle p reaches the detector at p+2; unit ticks follow every UC cycles.
    function automatic void model_mark(input int p, input int d);
        if (d > 15 * UC) begin
            exp_q.push_back(mk_ev(p + 2 + 15 * UC + 1, 0, 0, 1, 0, ""));
            cur_sym = ""; m_ovf = 1'b0; hist.delete();
        end else if (cur_sym.len() == 9) begin
            m_ovf = 1'b1;
        end else if (d / UC >= 2) begin
            cur_sym = $sformatf("%s-", cur_sym);
        end else begin
            cur_sym = $sformatf("%s.", cur_sym);
        end
    endfunction

    function automatic void model_space(input int p, input int d);
        bit sos;
        if ((cur_sym.len() > 0 || m_ovf) && d > 2 * UC) begin
            if (m_ovf) begin
                exp_q.push_back(mk_ev(p + 2 + 2 * UC + 1, 0, 0, 1, 0, ""));
                hist.delete();
            end else begin
                sos = (cur_sym == "...---...") ||
                      (hist.size() >= 2 && hist[hist.size() - 2] == "..." &&
                       hist[hist.size() - 1] == "---" && cur_sym == "...");
                last_chr = mk_ev(p + 2 + 2 * UC + 1, 1, 0, 0, sos, cur_sym);
                exp_q.push_back(last_chr);
                hist.push_back(cur_sym);
            end
            cur_sym = ""; m_ovf = 1'b0;
            if (d > 5 * UC) begin
                exp_q.push_back(mk_ev(p + 2 + 5 * UC + 1, 0, 1, 0, 0, ""));
                hist.delete();
            end
        end
    endfunction

    // Called at #1 after a posedge; leaves the bench at #1 after the posedge d cycles later.
    task automatic seg(input bit lvl, input int d);
        int p;
        p = cyc;
        iKEY = lvl;
        if (lvl) model_mark(p, d);
        else model_space(p, d);
        repeat (d) @(posedge iCLK);
        #1;
    endtask

    task automatic sym(input string s, input int gap_after);
        for (int i = 0; i < s.len(); i++) begin
            seg(1'b1, (s[i] == "-") ? 3 * UC : UC);
            if (i < s.len() - 1) seg(1'b0, UC);
        end
        seg(1'b0, gap_after);
    endtask

    always @(negedge iCLK) begin
        if (!iRST && (oCHAR_VALID || oWORD || oERR || oSOS)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {28'd0, oCHAR_VALID, oWORD, oERR, oSOS}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_cycle", cyc, mon_e.cyc);
                chk("ev_flags", {28'd0, oCHAR_VALID, oWORD, oERR, oSOS},
                    {28'd0, mon_e.chv, mon_e.word, mon_e.err, mon_e.sos});
                if (mon_e.chv) begin
                    chk("sym_len", oSYM_LEN, mon_e.len);
                    chk("sym_bits", oSYM_BITS, mon_e.bits);
                    chk("ascii", oASCII, mon_e.asc);
                end
            end
        end
    end

    // Sidetone watch: rKEY is iKEY two clocks late.
    logic kd1 = 1'b0, kd2 = 1'b0;
    int   snd_bad = 0, snd_hi = 0, snd_lo = 0;
    always @(posedge iCLK) begin
        if (iRST) begin kd1 <= 1'b0; kd2 <= 1'b0; end
        else begin kd1 <= iKEY; kd2 <= kd1; end
    end
    always @(negedge iCLK) begin
        if (!kd2 && oSOUND) snd_bad++;
        if (kd2 && oSOUND) snd_hi++;
        if (kd2 && !oSOUND) snd_lo++;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pulses"}, {28'd0, oCHAR_VALID, oWORD, oERR, oSOS}, 32'd0);
        chk({tag, "_len"}, oSYM_LEN, 4'd0);
        chk({tag, "_bits"}, oSYM_BITS, 9'd0);
        chk({tag, "_ascii"}, oASCII, 8'd0);
        chk({tag, "_sound"}, oSOUND, 1'b0);
    endtask

    initial begin
        int nel, md, gap;
        last_chr = mk_ev(0, 0, 0, 0, 0, "");
        repeat (3) @(posedge iCLK);
        #1;
        chk_all_zero("reset");
        iRST = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;

        sym(".", 40);
        sym("...---...", 40);
        sym("...", 12);
        sym("---", 12);
        sym("...", 40);
        sym("..........", 40);
        seg(1'b1, 15 * UC);
        seg(1'b0, 40);

        snd_hi = 0; snd_lo = 0;
        seg(1'b1, 64);
        seg(1'b0, 40);
        chk("sound_toggles_held", {31'd0, (snd_hi > 0 && snd_lo > 0)}, 32'd1);

        for (int s = 0; s < 25; s++) begin
            nel = $urandom_range(1, 11);
            for (int e = 0; e < nel; e++) begin
                md = ($urandom_range(0, 19) == 0) ? $urandom_range(58, 68) : $urandom_range(1, 14);
                seg(1'b1, md);
                if (e < nel - 1) seg(1'b0, $urandom_range(1, 8));
            end
            gap = (s == 24) ? 40 : $urandom_range(6, 30);
            seg(1'b0, gap);
        end

        iKEY = 1'b1;
        repeat (6) @(posedge iCLK);
        #1;
        iKEY = 1'b0;
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        chk_all_zero("mid_reset");
        iRST = 1'b0;
        cur_sym = ""; m_ovf = 1'b0; hist.delete();
        last_chr = mk_ev(0, 0, 0, 0, 0, "");
        repeat (2) @(posedge iCLK);
        #1;
        sym("-", 40);

        chk("hold_len", oSYM_LEN, last_chr.len);
        chk("hold_bits", oSYM_BITS, last_chr.bits);
        chk("hold_ascii", oASCII, last_chr.asc);
        chk("pending_events", exp_q.size(), 0);
        chk("sound_off_when_up", snd_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
